// File: rtl/flappy_pkg.sv
// Shared types and defaults for the pipe field scroller and its column generator.
package flappy_pkg;

    localparam int ROWS_DEF  = 8;
    localparam int COLS_DEF  = 8;
    localparam int GAP_ROW_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_e;

endpackage

// File: rtl/pipe_scroller_if.sv
// Control and field bus between the game controller and the pipe scroller.
interface pipe_scroller_if #(
    parameter int ROWS = 8,
    parameter int COLS = 8
);
    logic                 start;
    logic                 freeze;
    logic                 tick;
    logic [3:0]           rand_in;
    logic [ROWS*COLS-1:0] grid;
    logic                 pipe_spawn;
    logic                 pipe_passed;
    logic                 running;
    logic [7:0]           score;

    modport master (
        output start, freeze, tick, rand_in,
        input  grid, pipe_spawn, pipe_passed, running, score
    );

    modport slave (
        input  start, freeze, tick, rand_in,
        output grid, pipe_spawn, pipe_passed, running, score
    );
endinterface

// File: rtl/pipe_column_gen.sv
// Combinational pipe column: lit rows except a GAP_HEIGHT gap placed by the random value.
module pipe_column_gen
    import flappy_pkg::*;
#(
    parameter int ROWS       = ROWS_DEF,
    parameter int GAP_HEIGHT = 3
) (
    input  logic [GAP_ROW_W-1:0] rand_i,
    output logic [ROWS-1:0]      col_o
);
    localparam int                 MODULUS = ROWS - GAP_HEIGHT + 1;
    localparam logic [GAP_ROW_W:0] MOD_V   = MODULUS[GAP_ROW_W:0];

    logic [GAP_ROW_W:0] rem;
    int                 gi;

    // Repeated subtraction keeps the modulo free of a divider.
    always_comb begin
        rem = {1'b0, rand_i};
        for (int i = 0; i < (1 << GAP_ROW_W); i++) begin
            if (rem >= MOD_V) rem = rem - MOD_V;
        end
        gi = int'(rem);
        col_o = '0;
        for (int r = 0; r < ROWS; r++) begin
            col_o[r] = !((r >= gi) && (r < gi + GAP_HEIGHT));
        end
    end
endmodule

// File: rtl/pipe_scroller.sv
// Scrolling pipe field for the 8x8 display with spawn/pass strobes.
// Define PIPE_SCORE_EN to build the saturating pass counter on score; otherwise score is 0.
module pipe_scroller
    import flappy_pkg::*;
#(
    parameter int ROWS         = ROWS_DEF,
    parameter int COLS         = COLS_DEF,
    parameter int GAP_HEIGHT   = 3,
    parameter int PIPE_SPACING = 4
) (
    input  logic           clk,
    input  logic           reset,
    pipe_scroller_if.slave bus_if
);
    localparam int             CNT_W    = $clog2(PIPE_SPACING);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PIPE_SPACING - 1);

    state_e               state_q, state_d;
    logic [ROWS*COLS-1:0] grid_q, grid_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 spawn_q, spawn_d;
    logic                 passed_q, passed_d;
    logic                 running_q;
    logic [ROWS-1:0]      new_col;
    logic                 col0_lit;
    logic                 insert_pipe;

    pipe_column_gen #(
        .ROWS       (ROWS),
        .GAP_HEIGHT (GAP_HEIGHT)
    ) u_col_gen (
        .rand_i (bus_if.rand_in),
        .col_o  (new_col)
    );

    assign insert_pipe = (cnt_q == CNT_LAST);

    always_comb begin
        col0_lit = 1'b0;
        for (int r = 0; r < ROWS; r++) col0_lit = col0_lit | grid_q[r*COLS];
    end

    always_comb begin
        state_d  = state_q;
        grid_d   = grid_q;
        cnt_d    = cnt_q;
        spawn_d  = 1'b0;
        passed_d = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                grid_d = '0;
                cnt_d  = '0;
                if (bus_if.start) state_d = ST_RUN;
            end
            ST_RUN: begin
                // freeze outranks a coincident tick: the field stays put.
                if (bus_if.freeze) begin
                    state_d = ST_HALT;
                end else if (bus_if.tick) begin
                    passed_d = col0_lit;
                    for (int r = 0; r < ROWS; r++) begin
                        for (int c = 0; c < COLS - 1; c++) begin
                            grid_d[r*COLS+c] = grid_q[r*COLS+c+1];
                        end
                        grid_d[r*COLS+COLS-1] = insert_pipe & new_col[r];
                    end
                    if (insert_pipe) begin
                        cnt_d   = '0;
                        spawn_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            ST_HALT: begin
                if (bus_if.start) begin
                    state_d = ST_IDLE;
                    grid_d  = '0;
                    cnt_d   = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            grid_q    <= '0;
            cnt_q     <= '0;
            spawn_q   <= 1'b0;
            passed_q  <= 1'b0;
            running_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            grid_q    <= grid_d;
            cnt_q     <= cnt_d;
            spawn_q   <= spawn_d;
            passed_q  <= passed_d;
            running_q <= (state_d == ST_RUN);
        end
    end

`ifdef PIPE_SCORE_EN
    logic [7:0] score_q, score_d;

    always_comb begin
        score_d = score_q;
        if (state_q == ST_HALT && bus_if.start) begin
            score_d = '0;
        end else if (passed_d && score_q != 8'hFF) begin
            score_d = score_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) score_q <= '0;
        else       score_q <= score_d;
    end

    assign bus_if.score = score_q;
`else
    assign bus_if.score = '0;
`endif

    assign bus_if.grid        = grid_q;
    assign bus_if.pipe_spawn  = spawn_q;
    assign bus_if.pipe_passed = passed_q;
    assign bus_if.running     = running_q;
endmodule

// File: tb/tb_pipe_scroller.sv
// Bench for pipe_scroller: column-list model compared every cycle, plus literal spot checks.
module tb_pipe_scroller;
    logic clk   = 1'b0;
    logic reset = 1'b0;

`ifdef PIPE_SCORE_EN
    localparam int SCORE_ON = 1;
`else
    localparam int SCORE_ON = 0;
`endif

    pipe_scroller_if #(.ROWS(8), .COLS(8)) bus ();

    pipe_scroller #(
        .ROWS         (8),
        .COLS         (8),
        .GAP_HEIGHT   (3),
        .PIPE_SPACING (4)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .bus_if (bus)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;
    bit cmp_on = 1'b0;

    // Model: field as a list of 8 column masks, col 0 leftmost.
    logic [7:0] m_col [8];
    int         m_state = 0;   // 0 idle, 1 run, 2 halt
    int         m_cnt   = 0;
    int         m_score = 0;
    logic       m_spawn = 1'b0;
    logic       m_passed = 1'b0;

    function automatic logic [7:0] pipe_mask(input logic [3:0] r);
        int g;
        g = int'(r) % 6;
        return ~(8'h07 << g);
    endfunction

    function automatic logic [63:0] model_grid();
        logic [63:0] g;
        g = '0;
        for (int c = 0; c < 8; c++)
            for (int r = 0; r < 8; r++) g[r*8+c] = m_col[c][r];
        return g;
    endfunction

    function automatic logic [7:0] col_of(input logic [63:0] g, input int c);
        logic [7:0] v;
        for (int r = 0; r < 8; r++) v[r] = g[r*8+c];
        return v;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < 8; c++) m_col[c] = '0;
        m_state = 0; m_cnt = 0; m_score = 0; m_spawn = 1'b0; m_passed = 1'b0;
    endtask

    task automatic model_step();
        m_spawn  = 1'b0;
        m_passed = 1'b0;
        case (m_state)
            0: if (bus.start) begin m_state = 1; m_cnt = 0; end
            1: begin
                if (bus.freeze) m_state = 2;
                else if (bus.tick) begin
                    m_passed = (m_col[0] != 8'h00);
                    for (int c = 0; c < 7; c++) m_col[c] = m_col[c+1];
                    if (m_cnt == 3) begin
                        m_col[7] = pipe_mask(bus.rand_in);
                        m_cnt = 0;
                        m_spawn = 1'b1;
                    end else begin
                        m_col[7] = 8'h00;
                        m_cnt++;
                    end
                    if (SCORE_ON != 0 && m_passed && m_score < 255) m_score++;
                end
            end
            default: if (bus.start) begin
                m_state = 0;
                for (int c = 0; c < 8; c++) m_col[c] = '0;
                m_score = 0;
            end
        endcase
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or posedge reset);
            if (reset) model_reset();
            else       model_step();
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (cmp_on) begin
                chk("mdl_grid",    bus.grid,                model_grid());
                chk("mdl_spawn",   64'(bus.pipe_spawn),     64'(m_spawn));
                chk("mdl_passed",  64'(bus.pipe_passed),    64'(m_passed));
                chk("mdl_running", 64'(bus.running),        64'(m_state == 1));
                chk("mdl_score",   64'(bus.score),          64'(m_score));
            end
        end
    end

    task automatic do_tick(input logic [3:0] r);
        bus.tick    = 1'b1;
        bus.rand_in = r;
        @(posedge clk); #1;
        bus.tick    = 1'b0;
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    int          n_pass;
    logic [63:0] saved;

    initial begin
        bus.start = 1'b0; bus.freeze = 1'b0; bus.tick = 1'b0; bus.rand_in = 4'd0;
        #1  reset = 1'b1;
        #20 reset = 1'b0;
        cmp_on = 1'b1;
        @(posedge clk); #1;
        chk("rst_grid",    bus.grid,            64'd0);
        chk("rst_running", 64'(bus.running),    64'd0);
        chk("rst_score",   64'(bus.score),      64'd0);

        pulse_start();
        chk("run_rise", 64'(bus.running), 64'd1);

        n_pass = 0;
        for (int i = 1; i <= 3; i++) begin
            do_tick(4'(i));
            chk("pre_pipe_grid",  bus.grid,              64'd0);
            chk("pre_pipe_spawn", 64'(bus.pipe_spawn),   64'd0);
        end
        do_tick(4'd4);
        chk("pipe4_col7",  64'(col_of(bus.grid, 7)), 64'h8F);
        chk("pipe4_spawn", 64'(bus.pipe_spawn),      64'd1);
        @(posedge clk); #1;
        chk("spawn_one_cycle", 64'(bus.pipe_spawn), 64'd0);

        for (int i = 5; i <= 7; i++) begin
            do_tick(4'd9);
            n_pass += int'(bus.pipe_passed);
        end
        do_tick(4'd13);
        chk("pipe13_col7", 64'(col_of(bus.grid, 7)), 64'hF1);
        chk("pipe4_col3",  64'(col_of(bus.grid, 3)), 64'h8F);
        for (int i = 9; i <= 11; i++) begin
            do_tick(4'd2);
            n_pass += int'(bus.pipe_passed);
        end
        chk("no_pass_before_12", 64'(n_pass), 64'd0);
        do_tick(4'd15);
        n_pass += int'(bus.pipe_passed);
        chk("pipe15_col7",   64'(col_of(bus.grid, 7)), 64'hC7);
        chk("pass_on_12",    64'(bus.pipe_passed),     64'd1);
        chk("pass_count",    64'(n_pass),              64'd1);
        chk("score_after_1", 64'(bus.score),           64'(SCORE_ON));

        saved = bus.grid;
        bus.freeze = 1'b1; bus.tick = 1'b1; bus.rand_in = 4'd4;
        @(posedge clk); #1;
        bus.freeze = 1'b0; bus.tick = 1'b0;
        chk("frz_running", 64'(bus.running),     64'd0);
        chk("frz_grid",    bus.grid,             saved);
        chk("frz_spawn",   64'(bus.pipe_spawn),  64'd0);
        chk("frz_passed",  64'(bus.pipe_passed), 64'd0);
        for (int i = 0; i < 3; i++) do_tick(4'd3);
        chk("halt_tick_ignored", bus.grid, saved);
        pulse_start();
        chk("halt_to_idle_grid",    bus.grid,         64'd0);
        chk("halt_to_idle_running", 64'(bus.running), 64'd0);

        pulse_start();
        for (int i = 0; i < 6; i++) do_tick(4'd7);
        chk("grid_populated", 64'(bus.grid != 64'd0), 64'd1);
        @(negedge clk); #2;
        reset = 1'b1;
        #1;
        chk("async_grid",    bus.grid,         64'd0);
        chk("async_running", 64'(bus.running), 64'd0);
        chk("async_score",   64'(bus.score),   64'd0);
        chk("async_spawn",   64'(bus.pipe_spawn), 64'd0);
        #1 reset = 1'b0;
        @(posedge clk); #1;

        pulse_start();
        for (int i = 0; i < 1240; i++) do_tick(4'($urandom_range(0, 15)));
        chk("score_saturate", 64'(bus.score), 64'(SCORE_ON != 0 ? 255 : 0));

        @(posedge clk); #1;
        cmp_on = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
